data_mem_responder: RTL and testbench

Data-memory responder that serves the CPU's load/store port: it accepts `mem_rd`/`mem_wr` requests on a 12-bit word address and returns read data combinationally in the same cycle. Stores enter a small in-order write buffer that drains into a single-port backing array. The drain only runs in cycles without a load. Loads forward from the newest matching buffered store, so the CPU always sees coherent data.

---
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational loads with store forwarding from an
// in-order write buffer that drains into a single-port array on non-load cycles.
// Optional macro DMEM_MMIO_TIMER_EN maps the all-ones address to a cycle counter.
module data_mem_responder #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_rd,
  input  logic                        mem_wr,
  input  logic [ADDR_W-1:0]           ram_addr,
  input  logic [DATA_W-1:0]           data_mem_in,
  output logic [DATA_W-1:0]           data_mem_out,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_empty,
  output logic                        wb_full,
  output logic                        wb_overflow
);

  localparam int PTR_W     = $clog2(WB_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]   mem     [MEM_DEPTH];
  logic [ADDR_W-1:0]   wb_addr [WB_DEPTH];
  logic [DATA_W-1:0]   wb_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] wb_vld;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic                timer_hit;
  logic                drain;
  logic                room;
  logic                push;
  logic                drop;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic [PTR_W-1:0]    scan_idx;

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] timer_q;

  assign timer_hit = &ram_addr;

  // A store to the timer address restarts the count from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (mem_wr && timer_hit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`else
  assign timer_hit = 1'b0;
`endif

  // A load blocks the single array port, so draining only happens on non-load cycles.
  assign drain = !mem_rd && (count != '0);
  assign room  = (count != CNT_W'(WB_DEPTH)) || drain;
  assign push  = mem_wr && !timer_hit && room;
  assign drop  = mem_wr && !timer_hit && !room;

  // Scan oldest to newest so the newest matching entry is the one kept.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (wb_vld[scan_idx] && (wb_addr[scan_idx] == ram_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[scan_idx];
      end
    end
  end

  always_comb begin
    data_mem_out = fwd_hit ? fwd_data : mem[ram_addr];
`ifdef DMEM_MMIO_TIMER_EN
    if (timer_hit) begin
      data_mem_out = DATA_W'(timer_q);
    end
`endif
  end

  // When full with a drain, head and tail name the same slot: the drain clear
  // must come before the push set so the slot stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      wb_vld      <= '0;
      wb_overflow <= 1'b0;
    end else begin
      if (drain) begin
        wb_vld[head] <= 1'b0;
        head         <= head + PTR_W'(1);
      end
      if (push) begin
        wb_vld[tail] <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        wb_overflow <= 1'b1;
      end
    end
  end

  // Buffer payload and array contents are never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= ram_addr;
      wb_data[tail] <= data_mem_in;
    end
    if (drain) begin
      mem[wb_addr[head]] <= wb_data[head];
    end
  end

  assign wb_count = count;
  assign wb_empty = (count == '0);
  assign wb_full  = (count == CNT_W'(WB_DEPTH));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table plus randomized traffic
// checked against a queue/associative-array model of the buffered memory.
module tb_data_mem_responder;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int WB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic        mem_wr;
  logic [11:0] ram_addr;
  logic [31:0] data_mem_in;
  logic [31:0] data_mem_out;
  logic [2:0]  wb_count;
  logic        wb_empty;
  logic        wb_full;
  logic        wb_overflow;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .ram_addr    (ram_addr),
    .data_mem_in (data_mem_in),
    .data_mem_out(data_mem_out),
    .wb_count    (wb_count),
    .wb_empty    (wb_empty),
    .wb_full     (wb_full),
    .wb_overflow (wb_overflow)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] exp_out;
    int          exp_cnt;
    logic        exp_ovf;
  } vec_t;

  ent_t        ref_q[$];
  logic [31:0] ref_mem[int];
  bit          ref_ovf;
  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_lookup(input logic [11:0] a, output logic [31:0] v);
    for (int i = ref_q.size() - 1; i >= 0; i--) begin
      if (ref_q[i].addr == a) begin
        v = ref_q[i].data;
        return 1'b1;
      end
    end
    if (ref_mem.exists(int'(a))) begin
      v = ref_mem[int'(a)];
      return 1'b1;
    end
    v = '0;
    return 1'b0;
  endfunction

  task automatic ref_edge(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] d);
    ent_t e;
    if (!rd && ref_q.size() > 0) begin
      e = ref_q.pop_front();
      ref_mem[int'(e.addr)] = e.data;
    end
    if (wr) begin
      if (ref_q.size() < WB_DEPTH) begin
        e.addr = a;
        e.data = d;
        ref_q.push_back(e);
      end else begin
        ref_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] ev;
    bit          known;
    mem_rd = rd; mem_wr = wr; ram_addr = a; data_mem_in = d;
    @(negedge clk);
    known = ref_lookup(a, ev);
    if (known) chk("load_data", data_mem_out, ev);
    chk("wb_count", 32'(wb_count), 32'(ref_q.size()));
    chk("wb_empty", 32'(wb_empty), 32'(ref_q.size() == 0));
    chk("wb_full", 32'(wb_full), 32'(ref_q.size() == WB_DEPTH));
    chk("wb_overflow", 32'(wb_overflow), 32'(ref_ovf));
    @(posedge clk);
    ref_edge(rd, wr, a, d);
    #1;
  endtask

  task automatic do_reset();
    mem_rd = 1'b0; mem_wr = 1'b0; ram_addr = '0; data_mem_in = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_q.delete();
    ref_ovf = 1'b0;
  endtask

  task automatic add(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] eo, input int ec, input logic ov);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.din = d;
    v.exp_out = eo; v.exp_cnt = ec; v.exp_ovf = ov;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    mem_rd = 1'b0; mem_wr = 1'b0; ram_addr = '0; data_mem_in = '0;
    ref_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state over two idle cycles
    step(1'b0, 1'b0, 12'h000, 32'h0);
    step(1'b0, 1'b0, 12'h000, 32'h0);

    // Give every address the bench touches a known array value
    for (int a = 0; a < 64; a++) step(1'b0, 1'b1, 12'(a), 32'hA000_0000 | 32'(a));
    for (int a = 12'h100; a < 12'h110; a++) step(1'b0, 1'b1, 12'(a), 32'hA000_0000 | 32'(a));
    repeat (4) step(1'b0, 1'b0, 12'h000, 32'h0);

    // Forwarding
    add(0, 1, 12'h010, 32'hDEADBEEF, 32'hA000_0010, 0, 0);
    add(1, 0, 12'h010, 32'h0,        32'hDEADBEEF,  1, 0);
    add(0, 0, 12'h010, 32'h0,        32'hDEADBEEF,  1, 0);
    add(0, 0, 12'h010, 32'h0,        32'hDEADBEEF,  0, 0);
    // Newest wins and drain order
    add(0, 1, 12'h020, 32'd1, 32'hA000_0020, 0, 0);
    add(0, 1, 12'h020, 32'd2, 32'd1, 1, 0);
    add(0, 1, 12'h020, 32'd3, 32'd2, 1, 0);
    add(1, 0, 12'h020, 32'd0, 32'd3, 1, 0);
    add(0, 0, 12'h020, 32'd0, 32'd3, 1, 0);
    add(0, 0, 12'h020, 32'd0, 32'd3, 0, 0);
    add(0, 0, 12'h020, 32'd0, 32'd3, 0, 0);
    add(0, 0, 12'h020, 32'd0, 32'd3, 0, 0);
    add(1, 0, 12'h020, 32'd0, 32'd3, 0, 0);
    // Simultaneous enqueue and drain while full
    for (int i = 0; i < 4; i++)
      add(1, 1, 12'h030 + 12'(i), 32'hC0DE_0030 + 32'(i), 32'hA000_0030 + 32'(i), i, 0);
    add(0, 1, 12'h034, 32'hC0DE_0034, 32'hA000_0034, 4, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 12'h030 + 12'(i), 32'h0, 32'hC0DE_0030 + 32'(i), 4 - i, 0);
    // Fill and overflow
    for (int i = 0; i < 5; i++)
      add(1, 1, 12'h100 + 12'(i), 32'hF000_0100 + 32'(i), 32'hA000_0100 + 32'(i), i, 0);
    add(1, 0, 12'h104, 32'h0, 32'hA000_0104, 4, 1);
    add(1, 0, 12'h103, 32'h0, 32'hF000_0103, 4, 1);

    foreach (vecs[k]) begin
      mem_rd = vecs[k].rd; mem_wr = vecs[k].wr;
      ram_addr = vecs[k].addr; data_mem_in = vecs[k].din;
      @(negedge clk);
      chk($sformatf("vec%0d_out", k), data_mem_out, vecs[k].exp_out);
      chk($sformatf("vec%0d_count", k), 32'(wb_count), 32'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d_full", k), 32'(wb_full), 32'(vecs[k].exp_cnt == WB_DEPTH));
      chk($sformatf("vec%0d_empty", k), 32'(wb_empty), 32'(vecs[k].exp_cnt == 0));
      chk($sformatf("vec%0d_ovf", k), 32'(wb_overflow), 32'(vecs[k].exp_ovf));
      @(posedge clk);
      ref_edge(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].din);
      #1;
    end

    // Drain the filled buffer, overflow stays sticky
    repeat (5) step(1'b0, 1'b0, 12'h100, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'h100 + 12'(i), 32'h0);

    // Reset with three stores pending: they are lost, array data survives
    step(1'b1, 1'b1, 12'h008, 32'h5555_0008);
    step(1'b1, 1'b1, 12'h009, 32'h5555_0009);
    step(1'b1, 1'b1, 12'h00A, 32'h5555_000A);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_rd = 1'b1; mem_wr = 1'b0; ram_addr = 12'h008 + 12'(i);
      @(negedge clk);
      chk("rst_pending_lost", data_mem_out, 32'hA000_0008 + 32'(i));
      chk("rst_count", 32'(wb_count), 32'd0);
      chk("rst_ovf", 32'(wb_overflow), 32'd0);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic r, w;
      r = ($urandom_range(0, 9) < 4);
      w = ($urandom_range(0, 9) < 5);
      step(r, w, 12'($urandom_range(0, 15)), $urandom());
    end
    repeat (5) step(1'b0, 1'b0, 12'h000, 32'h0);

`ifdef DMEM_MMIO_TIMER_EN
    mem_rd = 1'b0; mem_wr = 1'b1; ram_addr = 12'hFFF; data_mem_in = 32'h1234_5678;
    @(posedge clk);
    #1;
    mem_rd = 1'b1; mem_wr = 1'b0;
    @(negedge clk);
    chk("timer_zero", data_mem_out, 32'd0);
    chk("timer_no_enqueue", 32'(wb_count), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("timer_one", data_mem_out, 32'd1);
    @(posedge clk);
    #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
